dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK (rising edge) and RST.
REQ-002 The block SHALL have parameter DMEM_SIZE, default 1024, meaning the number of 32-bit words in data memory; legal word addresses are 0..DMEM_SIZE-1.
REQ-003 The block SHALL have the following ports (name  direction  width  meaning):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- REQ  in  2  access request; bit 0 = CPU MEM stage, bit 1 = debug/DMA port
- WE  in  2  per-port write enable (1 = store, 0 = load)
- ADDR0, ADDR1  in  32  per-port word address
- WDATA0, WDATA1  in  32  per-port store data
- GNT  out  2  one-cycle grant pulse per port
- DONE  out  2  one-cycle completion pulse per port
- ERR  out  1  with DONE: address out of range
- RDATA  out  32  load data, valid while DONE is high for a load
- MEM_EN  out  1  memory cycle strobe
- MEM_WE  out  1  memory write
- MEM_ADDR  out  32  memory word address
- MEM_WDATA  out  32  memory write data
- MEM_RDATA  in  32  memory read data, valid one cycle after MEM_EN with MEM_WE=0

Function
REQ-004 The block SHALL implement the states IDLE, ACCESS and RDWAIT.
REQ-005 In IDLE with REQ != 0, the block SHALL select a winner and latch the winner's WE, ADDR and WDATA.
REQ-006 In that same IDLE cycle, the block SHALL register a GNT pulse for the winner, visible the next cycle, and SHALL move to ACCESS.
REQ-007 Arbitration SHALL be round-robin: a single pointer names the preferred port, and the pointer moves to the other port after every grant.
REQ-008 If only one port requests, that port SHALL win regardless of the pointer.
REQ-009 In ACCESS with the latched address < DMEM_SIZE, the block SHALL drive MEM_EN=1, MEM_WE=latched WE, MEM_ADDR=latched address and MEM_WDATA=latched data.
REQ-010 For a write, the block SHALL pulse DONE[winner] in ACCESS and return to IDLE.
REQ-011 For a read, the block SHALL go to RDWAIT; in RDWAIT it SHALL drive RDATA=MEM_RDATA, pulse DONE[winner] and return to IDLE.
REQ-012 For an address >= DMEM_SIZE (unsigned compare), ACCESS SHALL keep MEM_EN=0, pulse DONE[winner] with ERR=1 and RDATA=0, and return to IDLE.
REQ-013 A requester SHALL hold REQ, WE, ADDR and WDATA stable until it sees GNT; the block SHALL ignore input changes after the latch.
REQ-014 REQ seen in ACCESS or RDWAIT SHALL be held pending and arbitrated on the next IDLE cycle.
REQ-015 Best-case throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-016 GNT, DONE and ERR SHALL be single-cycle pulses; at most one bit of GNT and at most one bit of DONE SHALL be high in any cycle.
REQ-017 MEM_EN SHALL be high only in ACCESS.
REQ-018 RDATA SHALL hold its last value outside DONE cycles.
REQ-019 A granted port SHALL deassert REQ the cycle after GNT unless it is issuing a new request.
REQ-020 When both ports request continuously, grants SHALL alternate 0,1,0,1...; neither port SHALL wait more than one other transaction.

Reset
REQ-021 When RST=1 at a rising CLK, the block SHALL go to IDLE, set the round-robin pointer to port 0, and clear GNT, DONE, ERR, RDATA, MEM_EN, MEM_WE, MEM_ADDR and MEM_WDATA.
REQ-022 A reset during ACCESS or RDWAIT SHALL abort the transaction with no DONE, and the abort SHALL not be replayed.
REQ-023 Memory contents SHALL not be affected by reset.

Structure
REQ-024 The state encoding, port indices and the DMEM_SIZE default SHALL live in the shared common parameter file alongside the existing opcode constants.
REQ-025 The round-robin selector SHALL be one sub-module, rr_pick2, taking inputs req and pointer and producing output grant.
REQ-026 Everything else SHALL be in one module.

Verification
REQ-027 Reset check: RST for 2 cycles, then release -> all outputs 0, state IDLE, first single REQ=01 granted.
REQ-028 CPU write: REQ=01, WE=01, ADDR0=5, WDATA0=0xDEADBEEF -> GNT=01 at cycle+1; MEM_EN=1, MEM_WE=1, MEM_ADDR=5 and DONE=01 at cycle+1; back in IDLE at cycle+2.
REQ-029 Debug read: preload word 5 = 0xDEADBEEF, then REQ=10, WE=00, ADDR1=5 -> DONE=10 with RDATA=0xDEADBEEF exactly 2 cycles after GNT.
REQ-030 Contention: both ports hold REQ for 8 transactions -> grant order 0,1,0,1,0,1,0,1, with no port granted twice in a row.
REQ-031 Out of range: ADDR0=1024 with DMEM_SIZE=1024 -> MEM_EN stays 0, DONE=01, ERR=1, RDATA=0.
REQ-032 Reset in RDWAIT: assert RST in the RDWAIT cycle of a read -> no DONE, IDLE next cycle, pointer = port 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory path: opcodes, arbiter state encoding,
// port indices and the default data-memory depth.
package dmem_arbiter_pkg;

    // Load/store major opcodes used by the MEM stage decoder.
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Number of 32-bit words in data memory unless overridden.
    localparam int DMEM_SIZE_DEFAULT = 1024;

    // Requester indices on REQ/WE/GNT/DONE.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    // One-hot request/grant vector for a port index.
    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] vec;
        vec = 2'b00;
        if (port == PORT_DBG) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester always wins, on contention
// the port named by the pointer wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] grant
);

    // Pick at most one requester, preferring the pointer on a tie.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = pointer ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage (port 0) and the debug/DMA
// port (port 1). Writes finish in ACCESS, reads wait one extra cycle for the
// synchronous memory and complete with DONE in the following cycle.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_SIZE = DMEM_SIZE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  REQ,
    input  logic [1:0]  WE,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic [1:0]  GNT,
    output logic [1:0]  DONE,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic        MEM_EN,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_SIZE);

    state_t      state_r;
    logic        ptr_r;       // preferred port on the next tie
    logic        port_r;      // port owning the transaction in flight
    logic        rd_r;        // in-range load in flight, needs RDWAIT
    logic [1:0]  pick_s;
    logic        win_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_ok_s;

    rr_pick2 u_pick (
        .req     (REQ),
        .pointer (ptr_r),
        .grant   (pick_s)
    );

    // Steer the winning port's command fields and range-check its address.
    always_comb begin
        win_s       = pick_s[1];
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (win_s == PORT_DBG) begin
            sel_we_s    = WE[1];
            sel_addr_s  = ADDR1;
            sel_wdata_s = WDATA1;
        end else begin
            sel_we_s    = WE[0];
            sel_addr_s  = ADDR0;
            sel_wdata_s = WDATA0;
        end
        sel_ok_s = (sel_addr_s < DMEM_LIMIT);
    end

    // Arbitration FSM; every output is registered so it lines up with the
    // state it belongs to (GNT/MEM_* in ACCESS, read DONE after RDWAIT).
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            ptr_r     <= PORT_CPU;
            port_r    <= PORT_CPU;
            rd_r      <= 1'b0;
            GNT       <= 2'b00;
            DONE      <= 2'b00;
            ERR       <= 1'b0;
            RDATA     <= 32'd0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 32'd0;
            MEM_WDATA <= 32'd0;
        end else begin
            GNT    <= 2'b00;
            DONE   <= 2'b00;
            ERR    <= 1'b0;
            MEM_EN <= 1'b0;
            MEM_WE <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (REQ != 2'b00) begin
                        GNT       <= pick_s;
                        port_r    <= win_s;
                        ptr_r     <= ~win_s;
                        MEM_ADDR  <= sel_addr_s;
                        MEM_WDATA <= sel_wdata_s;
                        state_r   <= ST_ACCESS;
                        if (!sel_ok_s) begin
                            DONE  <= pick_s;
                            ERR   <= 1'b1;
                            RDATA <= 32'd0;
                            rd_r  <= 1'b0;
                        end else if (sel_we_s) begin
                            MEM_EN <= 1'b1;
                            MEM_WE <= 1'b1;
                            DONE   <= pick_s;
                            rd_r   <= 1'b0;
                        end else begin
                            MEM_EN <= 1'b1;
                            MEM_WE <= 1'b0;
                            rd_r   <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r <= rd_r ? ST_RDWAIT : ST_IDLE;
                end
                ST_RDWAIT: begin
                    RDATA   <= MEM_RDATA;
                    DONE    <= port_onehot(port_r);
                    rd_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small synchronous
// memory model attached to the MEM_* port.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        CLK;
    logic        RST;
    logic [1:0]  REQ;
    logic [1:0]  WE;
    logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1;
    logic [1:0]  GNT, DONE;
    logic        ERR;
    logic [31:0] RDATA;
    logic        MEM_EN, MEM_WE;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_q;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.DMEM_SIZE(1024)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT(GNT), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous memory: read data appears the cycle after the strobe.
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) begin
                mem[MEM_ADDR[9:0]] <= MEM_WDATA;
            end else begin
                mem_q <= mem[MEM_ADDR[9:0]];
            end
        end
    end
    assign MEM_RDATA = mem_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0] exp_g;
        mem_q  = 32'd0;
        RST    = 1'b1;
        REQ    = 2'b00;
        WE     = 2'b00;
        ADDR0  = 32'd0;
        ADDR1  = 32'd0;
        WDATA0 = 32'd0;
        WDATA1 = 32'd0;

        // Reset for two cycles.
        tick();
        tick();
        RST = 1'b0;
        check("rst_gnt",   32'(GNT), 32'd0);
        check("rst_done",  32'(DONE), 32'd0);
        check("rst_err",   32'(ERR), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_men",   32'(MEM_EN), 32'd0);
        check("rst_mwe",   32'(MEM_WE), 32'd0);
        check("rst_maddr", MEM_ADDR, 32'd0);
        check("rst_mwd",   MEM_WDATA, 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        check("rst_ptr",   32'(dut.ptr_r), 32'd0);

        // CPU write of 0xDEADBEEF to word 5.
        REQ = 2'b01; WE = 2'b01; ADDR0 = 32'd5; WDATA0 = 32'hDEADBEEF;
        tick();
        check("wr_gnt",   32'(GNT), 32'd1);
        check("wr_men",   32'(MEM_EN), 32'd1);
        check("wr_mwe",   32'(MEM_WE), 32'd1);
        check("wr_maddr", MEM_ADDR, 32'd5);
        check("wr_mwd",   MEM_WDATA, 32'hDEADBEEF);
        check("wr_done",  32'(DONE), 32'd1);
        check("wr_state", 32'(dut.state_r), 32'(ST_ACCESS));
        REQ = 2'b00; WE = 2'b00; ADDR0 = 32'd77; WDATA0 = 32'd0;
        tick();
        check("wr_idle",  32'(dut.state_r), 32'(ST_IDLE));
        check("wr_done0", 32'(DONE), 32'd0);
        check("wr_men0",  32'(MEM_EN), 32'd0);
        check("wr_mem5",  mem[5], 32'hDEADBEEF);

        // Debug read of word 5: DONE two cycles after GNT.
        REQ = 2'b10; WE = 2'b00; ADDR1 = 32'd5;
        tick();
        check("rd_gnt",   32'(GNT), 32'd2);
        check("rd_men",   32'(MEM_EN), 32'd1);
        check("rd_mwe",   32'(MEM_WE), 32'd0);
        check("rd_maddr", MEM_ADDR, 32'd5);
        check("rd_done0", 32'(DONE), 32'd0);
        REQ = 2'b00; ADDR1 = 32'd0;
        tick();
        check("rd_wait",  32'(dut.state_r), 32'(ST_RDWAIT));
        check("rd_done1", 32'(DONE), 32'd0);
        tick();
        check("rd_done",  32'(DONE), 32'd2);
        check("rd_data",  RDATA, 32'hDEADBEEF);
        check("rd_err",   32'(ERR), 32'd0);
        tick();
        check("rd_hold",  RDATA, 32'hDEADBEEF);
        check("rd_done2", 32'(DONE), 32'd0);

        // Both ports request continuously: grants alternate 0,1,0,1...
        REQ = 2'b11; WE = 2'b11; ADDR0 = 32'd10; ADDR1 = 32'd20;
        WDATA0 = 32'h0000AAAA; WDATA1 = 32'h0000BBBB;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("rr_gnt%0d", i), 32'(GNT), 32'(exp_g));
            check($sformatf("rr_done%0d", i), 32'(DONE), 32'(exp_g));
            tick();
        end
        REQ = 2'b00; WE = 2'b00;
        check("rr_mem10", mem[10], 32'h0000AAAA);
        check("rr_mem20", mem[20], 32'h0000BBBB);

        // Out-of-range load at the first illegal word.
        REQ = 2'b01; WE = 2'b00; ADDR0 = 32'd1024;
        tick();
        check("oor_gnt",   32'(GNT), 32'd1);
        check("oor_men",   32'(MEM_EN), 32'd0);
        check("oor_done",  32'(DONE), 32'd1);
        check("oor_err",   32'(ERR), 32'd1);
        check("oor_rdata", RDATA, 32'd0);
        REQ = 2'b00;
        tick();
        check("oor_err0",  32'(ERR), 32'd0);
        check("oor_men0",  32'(MEM_EN), 32'd0);
        check("oor_idle",  32'(dut.state_r), 32'(ST_IDLE));

        // Lone CPU read while pointer favours port 1, then reset in RDWAIT.
        REQ = 2'b01; WE = 2'b00; ADDR0 = 32'd5;
        tick();
        check("ab_gnt",   32'(GNT), 32'd1);
        REQ = 2'b00;
        tick();
        check("ab_wait",  32'(dut.state_r), 32'(ST_RDWAIT));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("ab_done",  32'(DONE), 32'd0);
        check("ab_idle",  32'(dut.state_r), 32'(ST_IDLE));
        check("ab_ptr",   32'(dut.ptr_r), 32'd0);
        tick();
        check("ab_nodone", 32'(DONE), 32'd0);
        check("ab_nomen",  32'(MEM_EN), 32'd0);
        check("ab_mem5",   mem[5], 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
